// File: rtl/motor_pkg.sv
// motor_pkg -- shared encodings and constants for motor_pwm_driver.
// Holds the command direction codes, the channel state encoding, the
// power-code-to-duty lookup and the width of the dead-time counter.
// The optional soft ramp (macro SOFT_RAMP_EN) lives in motor_channel.
package motor_pkg;

    // Direction field of a motor command, bits [1:0]
    localparam logic [1:0] DIR_FWD     = 2'b00;
    localparam logic [1:0] DIR_NEUTRAL = 2'b01;
    localparam logic [1:0] DIR_REV     = 2'b10;
    localparam logic [1:0] DIR_ILLEGAL = 2'b11;

    localparam int CMD_W   = 5;   // {power[2:0], dir[1:0]}
    localparam int PHASE_W = 3;   // eight ticks per PWM period
    localparam int DUTY_W  = 3;   // duty expressed in eighths, 0..7
    localparam int DEAD_W  = 4;   // holds DEAD_PERIODS up to 15

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DEAD  = 2'd3
    } chan_state_t;

    // Duty in eighths indexed by power code: code n gives n+1, except
    // code 7 which is held at 7/8 so the bootstrap supply can recharge.
    localparam logic [8*DUTY_W-1:0] DUTY_LUT = {
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1
    };

    function automatic logic [DUTY_W-1:0] duty_of(input logic [2:0] power);
        return DUTY_LUT[int'(power)*DUTY_W +: DUTY_W];
    endfunction

endpackage

// File: rtl/motor_channel.sv
// motor_channel -- one H-bridge channel: direction FSM, dead-time counter,
// duty register and registered bridge outputs. Commands are acted on only
// at period end, so a period in progress is never cut short or stretched.
// Build option SOFT_RAMP_EN: duty walks one eighth per period toward the
// commanded value and every entry into FWD/REV starts from duty 1.
module motor_channel
    import motor_pkg::*;
#(
    parameter int DEAD_PERIODS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_period_end,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [CMD_W-1:0]   i_cmd,
    output logic               o_ina,
    output logic               o_inb,
    output logic               o_pwm,
    output logic               o_busy,
    output logic               o_illegal
);

    chan_state_t         r_state;
    logic [DEAD_W-1:0]   r_dead;
    logic [DUTY_W-1:0]   r_duty;
    logic                r_illegal;
    logic                r_ina;
    logic                r_inb;
    logic                r_pwm;
    logic                r_busy;
    logic                r_illegal_out;

    logic [1:0]          w_dir;
    logic [DUTY_W-1:0]   w_target;
    logic [DUTY_W-1:0]   w_entry_duty;
    logic [DUTY_W-1:0]   w_hold_duty;

    assign w_dir    = i_cmd[1:0];
    assign w_target = duty_of(i_cmd[4:2]);

`ifdef SOFT_RAMP_EN
    // Ramp: start every drive phase at 1/8 and move one step per period.
    always_comb begin
        // NOTE: both outputs get a value on every path, so no latch is inferred.
        w_entry_duty = DUTY_W'(1);
        w_hold_duty  = r_duty;
        if (r_duty < w_target) begin
            w_hold_duty = r_duty + DUTY_W'(1);
        end else if (r_duty > w_target) begin
            w_hold_duty = r_duty - DUTY_W'(1);
        end
    end
`else
    assign w_entry_duty = w_target;
    assign w_hold_duty  = w_target;
`endif

    // Channel FSM: state, dead counter and duty advance at period end;
    // bridge outputs are re-registered every clock from the settled state.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous -- tested inside the clocked block, not in the sensitivity list.
        if (i_rst) begin
            r_state       <= ST_COAST;
            r_dead        <= '0;
            r_duty        <= '0;
            r_illegal     <= 1'b0;
            r_ina         <= 1'b0;
            r_inb         <= 1'b0;
            r_pwm         <= 1'b0;
            r_busy        <= 1'b0;
            r_illegal_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments -- every right-hand side sees the pre-edge state.
            r_ina         <= (r_state == ST_FWD);
            r_inb         <= (r_state == ST_REV);
            r_pwm         <= ((r_state == ST_FWD) || (r_state == ST_REV)) &&
                             (i_phase < r_duty);
            r_busy        <= (r_state == ST_DEAD);
            r_illegal_out <= r_illegal;

            if (i_period_end) begin
                if (w_dir == DIR_ILLEGAL) begin
                    r_illegal <= 1'b1;
                end

                case (r_state)
                    ST_COAST: begin
                        if (w_dir == DIR_FWD) begin
                            r_state <= ST_FWD;
                            r_duty  <= w_entry_duty;
                        end else if (w_dir == DIR_REV) begin
                            r_state <= ST_REV;
                            r_duty  <= w_entry_duty;
                        end
                    end

                    ST_FWD: begin
                        if (w_dir == DIR_FWD) begin
                            r_duty <= w_hold_duty;
                        end else if (w_dir == DIR_REV) begin
                            // Reversal always passes through coast time.
                            r_state <= ST_DEAD;
                            r_dead  <= DEAD_W'(DEAD_PERIODS);
                            r_duty  <= '0;
                        end else begin
                            r_state <= ST_COAST;
                            r_duty  <= '0;
                        end
                    end

                    ST_REV: begin
                        if (w_dir == DIR_REV) begin
                            r_duty <= w_hold_duty;
                        end else if (w_dir == DIR_FWD) begin
                            r_state <= ST_DEAD;
                            r_dead  <= DEAD_W'(DEAD_PERIODS);
                            r_duty  <= '0;
                        end else begin
                            r_state <= ST_COAST;
                            r_duty  <= '0;
                        end
                    end

                    ST_DEAD: begin
                        if (r_dead <= DEAD_W'(1)) begin
                            // Last dead period: follow the command sampled now.
                            r_dead <= '0;
                            if (w_dir == DIR_FWD) begin
                                r_state <= ST_FWD;
                                r_duty  <= w_entry_duty;
                            end else if (w_dir == DIR_REV) begin
                                r_state <= ST_REV;
                                r_duty  <= w_entry_duty;
                            end else begin
                                r_state <= ST_COAST;
                            end
                        end else begin
                            r_dead <= r_dead - DEAD_W'(1);
                        end
                    end

                    default: begin
                        r_state <= ST_COAST;
                        r_duty  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_ina     = r_ina;
    assign o_inb     = r_inb;
    assign o_pwm     = r_pwm;
    assign o_busy    = r_busy;
    assign o_illegal = r_illegal_out;

endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver -- two-channel H-bridge PWM driver. A shared prescaler
// and 3-bit phase counter define an 8-tick PWM period; both channels act
// on the same period-end strobe. Build option SOFT_RAMP_EN enables the
// per-period duty ramp inside each channel.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CLK_DIV      = 195,
    parameter int DEAD_PERIODS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CMD_W-1:0] MC1,
    input  logic [CMD_W-1:0] MC2,
    output logic             M1_INA,
    output logic             M1_INB,
    output logic             M1_PWM,
    output logic             M2_INA,
    output logic             M2_INB,
    output logic             M2_PWM,
    output logic [1:0]       BUSY,
    output logic [1:0]       ILLEGAL
);

    localparam int PRESC_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PRESC_W-1:0] r_presc;
    logic [PHASE_W-1:0] r_phase;
    logic               w_tick;
    logic               w_period_end;

    assign w_tick       = (r_presc == PRESC_W'(CLK_DIV - 1));
    assign w_period_end = w_tick && (r_phase == '1);

    // Prescaler 0..CLK_DIV-1 and the phase counter it advances; 7 wraps to 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= '0;
            r_phase <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_phase <= r_phase + PHASE_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Right motor
    motor_channel #(
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_ch1 (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_period_end (w_period_end),
        .i_phase      (r_phase),
        .i_cmd        (MC1),
        .o_ina        (M1_INA),
        .o_inb        (M1_INB),
        .o_pwm        (M1_PWM),
        .o_busy       (BUSY[0]),
        .o_illegal    (ILLEGAL[0])
    );

    // Left motor
    motor_channel #(
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_ch2 (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_period_end (w_period_end),
        .i_phase      (r_phase),
        .i_cmd        (MC2),
        .o_ina        (M2_INA),
        .o_inb        (M2_INB),
        .o_pwm        (M2_PWM),
        .o_busy       (BUSY[1]),
        .o_illegal    (ILLEGAL[1])
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver -- bench for motor_pwm_driver with CLK_DIV=4 and
// DEAD_PERIODS=4 (PWM period = 32 clocks). Honors SOFT_RAMP_EN when defined.
module tb_motor_pwm_driver;

    localparam int CLK_DIV      = 4;
    localparam int DEAD_PERIODS = 4;
    localparam int PERIOD_CLKS  = 8 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] mc1 = 5'b00001;
    logic [4:0] mc2 = 5'b00001;
    logic       m1_ina, m1_inb, m1_pwm;
    logic       m2_ina, m2_inb, m2_pwm;
    logic [1:0] busy, illegal;

    motor_pwm_driver #(
        .CLK_DIV      (CLK_DIV),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .MC1     (mc1),
        .MC2     (mc2),
        .M1_INA  (m1_ina),
        .M1_INB  (m1_inb),
        .M1_PWM  (m1_pwm),
        .M2_INA  (m2_ina),
        .M2_INB  (m2_inb),
        .M2_PWM  (m2_pwm),
        .BUSY    (busy),
        .ILLEGAL (illegal)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Clock edges since reset release, and the period-level reference state:
    // m_dir +1 forward, -1 reverse, 0 idle; m_dead = dead periods still owed.
    int e = 0;
    int m_dir  [2];
    int m_dead [2];
    int m_duty [2];
    bit m_ill  [2];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int target_duty(input logic [2:0] pw);
        return (pw == 3'd7) ? 7 : int'(pw) + 1;
    endfunction

    function automatic int dir_sign(input logic [1:0] d);
        if (d == 2'b00) return 1;
        if (d == 2'b10) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_dir[c] = 0; m_dead[c] = 0; m_duty[c] = 0; m_ill[c] = 1'b0;
        end
    endtask

    // One period boundary for channel c with the command present at that edge.
    task automatic model_period(input int c, input logic [4:0] cmd);
        int s, t, prev;
        s    = dir_sign(cmd[1:0]);
        t    = target_duty(cmd[4:2]);
        prev = m_dir[c];
        if (cmd[1:0] == 2'b11) m_ill[c] = 1'b1;
        if (m_dead[c] > 0) begin
            m_dead[c] = m_dead[c] - 1;
            if (m_dead[c] == 0) m_dir[c] = s;
        end else if (prev != 0 && s == -prev) begin
            m_dead[c] = DEAD_PERIODS;
            m_dir[c]  = 0;
        end else begin
            m_dir[c] = s;
        end
        if (m_dir[c] == 0) m_duty[c] = 0;
`ifdef SOFT_RAMP_EN
        else if (prev == 0)     m_duty[c] = 1;
        else if (m_duty[c] < t) m_duty[c] = m_duty[c] + 1;
        else if (m_duty[c] > t) m_duty[c] = m_duty[c] - 1;
`else
        else m_duty[c] = t;
`endif
    endtask

    function automatic logic [9:0] model_outputs(input int ph);
        logic [9:0] v;
        v[9] = (m_dir[0] == 1);
        v[8] = (m_dir[0] == -1);
        v[7] = (m_dir[0] != 0) && (ph < m_duty[0]);
        v[6] = (m_dir[1] == 1);
        v[5] = (m_dir[1] == -1);
        v[4] = (m_dir[1] != 0) && (ph < m_duty[1]);
        v[3] = (m_dead[1] > 0);
        v[2] = (m_dead[0] > 0);
        v[1] = m_ill[1];
        v[0] = m_ill[0];
        return v;
    endfunction

    function automatic logic [9:0] actual_v();
        return {m1_ina, m1_inb, m1_pwm, m2_ina, m2_inb, m2_pwm, busy, illegal};
    endfunction

    // Advance one clock; outputs after edge e follow the model state after edge e-1.
    task automatic tick();
        logic [9:0] exp_v;
        int ph;
        @(posedge clk);
        if (rst) begin
            exp_v = '0;
            e     = 0;
            model_reset();
        end else begin
            e++;
            ph    = ((e - 1) / CLK_DIV) % 8;
            exp_v = model_outputs(ph);
            if (e % PERIOD_CLKS == 0) begin
                model_period(0, mc1);
                model_period(1, mc2);
            end
        end
        @(negedge clk);
        check("outputs", int'(actual_v()), int'(exp_v));
        check("ina_inb_interlock", int'((m1_ina & m1_inb) | (m2_ina & m2_inb)), 0);
    endtask

    task automatic run_window(output int hi1, output int hi2);
        hi1 = 0;
        hi2 = 0;
        for (int i = 0; i < PERIOD_CLKS; i++) begin
            tick();
            hi1 += int'(m1_pwm);
            hi2 += int'(m2_pwm);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] rand_cmd();
        logic [1:0] d;
        logic [2:0] p;
        case ($urandom_range(0, 5))
            0, 1:    d = 2'b00;
            2, 3:    d = 2'b10;
            4:       d = 2'b01;
            default: d = 2'b11;
        endcase
        p = 3'($urandom_range(0, 7));
        return {p, d};
    endfunction

    typedef struct {
        logic [4:0] mc1;
        logic [4:0] mc2;
        int         n;      // periods to hold the command
        logic [1:0] leg1;   // {M1_INA, M1_INB} at end of last period
        logic [1:0] leg2;
        int         hi1;    // M1_PWM high clocks in the last period
        int         hi2;
        logic [1:0] busy;
        logic [1:0] ill;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int h1, h2;

        vecs[0] = '{5'b00100, 5'b00001, 2, 2'b10, 2'b00,  8,  0, 2'b00, 2'b00};
        vecs[1] = '{5'b00110, 5'b11000, 2, 2'b00, 2'b10,  0, 28, 2'b01, 2'b00};
        vecs[2] = '{5'b00110, 5'b11000, 3, 2'b00, 2'b10,  0, 28, 2'b01, 2'b00};
        vecs[3] = '{5'b00110, 5'b11000, 1, 2'b01, 2'b10,  8, 28, 2'b00, 2'b00};
        vecs[4] = '{5'b00011, 5'b00101, 2, 2'b00, 2'b00,  0,  0, 2'b00, 2'b01};
        vecs[5] = '{5'b00000, 5'b11110, 2, 2'b10, 2'b01,  4, 28, 2'b00, 2'b01};
        vecs[6] = '{5'b00010, 5'b11100, 2, 2'b00, 2'b00,  0,  0, 2'b11, 2'b01};
        vecs[7] = '{5'b00001, 5'b01101, 4, 2'b00, 2'b00,  0,  0, 2'b00, 2'b01};

        model_reset();
        reset_dut();
        check("reset_outputs", int'(actual_v()), 0);

        // Table: each command held for n periods, last period summarised.
        for (int i = 0; i < 8; i++) begin
            mc1 = vecs[i].mc1;
            mc2 = vecs[i].mc2;
            for (int k = 0; k < vecs[i].n; k++) run_window(h1, h2);
            check($sformatf("v%0d_leg1", i), int'({m1_ina, m1_inb}), int'(vecs[i].leg1));
            check($sformatf("v%0d_leg2", i), int'({m2_ina, m2_inb}), int'(vecs[i].leg2));
            check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].busy));
            check($sformatf("v%0d_illegal", i), int'(illegal), int'(vecs[i].ill));
`ifndef SOFT_RAMP_EN
            check($sformatf("v%0d_hi1", i), h1, vecs[i].hi1);
            check($sformatf("v%0d_hi2", i), h2, vecs[i].hi2);
`endif
        end

        // Power change mid-period only takes effect at the next period.
        reset_dut();
        mc1 = 5'b00001;
        mc2 = 5'b00000;
        run_window(h1, h2);
        run_window(h1, h2);
        h2 = 0;
        for (int i = 0; i < PERIOD_CLKS; i++) begin
            if (i == 12) mc2 = 5'b11000;
            tick();
            h2 += int'(m2_pwm);
        end
        check("midperiod_current", h2, 4);
        run_window(h1, h2);
`ifndef SOFT_RAMP_EN
        check("midperiod_next", h2, 28);
`else
        check("midperiod_next_ramp", h2, 8);
`endif

        // Reset during DEAD aborts at once and restarts from COAST.
        reset_dut();
        mc1 = 5'b00100;
        mc2 = 5'b00001;
        run_window(h1, h2);
        run_window(h1, h2);
        mc1 = 5'b00110;
        run_window(h1, h2);
        run_window(h1, h2);
        check("dead_busy", int'(busy), 1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("rst_abort", int'(actual_v()), 0);
        rst = 1'b0;
        run_window(h1, h2);
        run_window(h1, h2);
        check("after_rst_leg1", int'({m1_ina, m1_inb}), 1);
        check("after_rst_busy", int'(busy), 0);
`ifndef SOFT_RAMP_EN
        check("after_rst_hi1", h1, 8);
`endif

`ifdef SOFT_RAMP_EN
        // Ramp from COAST at full power: 1/8, 2/8 ... 7/8.
        reset_dut();
        mc1 = 5'b11100;
        mc2 = 5'b00001;
        run_window(h1, h2);
        for (int k = 1; k <= 7; k++) begin
            run_window(h1, h2);
            check($sformatf("ramp_step%0d", k), h1, k * CLK_DIV);
        end
`endif

        // Random commands changed at arbitrary points, occasional resets.
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) mc1 = rand_cmd();
            if ($urandom_range(0, 1) == 1) mc2 = rand_cmd();
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(8, 90)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 Parameter CLK_DIV, default 195, CLK cycles per PWM tick (legal range 2..65535).
REQ-002 Parameter DEAD_PERIODS, default 4, number of PWM periods of forced coast on a direction reversal (legal range 1..15).
REQ-003 CLK  input  1  system clock; all logic is on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 MC1  input  5  right motor command; [1:0] direction (00 forward, 01 neutral, 10 reverse, 11 illegal), [4:2] power code.
REQ-006 MC2  input  5  left motor command; same encoding as MC1.
REQ-007 M1_INA, M1_INB, M1_PWM  output  1 each  right H-bridge: forward leg, reverse leg, enable PWM.
REQ-008 M2_INA, M2_INB, M2_PWM  output  1 each  left H-bridge; same meaning as M1.
REQ-009 BUSY  output  2  bit0/bit1 high while channel 1/2 is in DEAD.
REQ-010 ILLEGAL  output  2  sticky flag per channel; set when direction 11 is sampled.

Function
REQ-011 A prescaler SHALL count 0..CLK_DIV-1 and pulse TICK for one CLK when the count equals CLK_DIV-1.
REQ-012 A shared 3-bit phase counter SHALL increment on each TICK and wrap 7->0; one PWM period = 8 ticks = 8*CLK_DIV clocks.
REQ-013 PERIOD_END SHALL be TICK AND phase==7; MC1/MC2 SHALL be sampled only at PERIOD_END, so input changes mid-period never alter the current period.
REQ-014 Duty in eighths: power code n -> n+1 for n=0..6; code 7 -> 7 (87.5% cap).
REQ-015 Mx_PWM SHALL be high while phase < applied duty, only in FWD/REV; otherwise 0.
REQ-016 Per-channel FSM states COAST, FWD, REV, DEAD; transitions are evaluated only at PERIOD_END, using the sampled direction.
REQ-017 COAST: INA=INB=PWM=0; sampled 00 -> FWD, 10 -> REV, 01/11 -> stay.
REQ-018 FWD: INA=1, INB=0; 00 -> stay with duty update, 01/11 -> COAST, 10 -> DEAD with the dead counter loaded to DEAD_PERIODS.
REQ-019 REV: INA=0, INB=1; mirror of REQ-018 (10 stays, 00 -> DEAD).
REQ-020 DEAD: INA=INB=PWM=0, BUSY=1; counter decrements at each PERIOD_END; at the PERIOD_END where it reaches 0, go to the state selected by the direction sampled at that edge (00 FWD, 10 REV, else COAST).
REQ-021 INA and INB SHALL never both be 1 in any cycle; a direct FWD<->REV transition is impossible.
REQ-022 Direction 11 SHALL be treated as neutral and SHALL set ILLEGAL[x]; ILLEGAL is cleared only by RST.
REQ-023 Channels are independent; both channels share the TICK and phase counter, and their PERIOD_END edges are coincident.
REQ-024 All outputs SHALL be registered; the registered output changes one CLK after the PERIOD_END edge.

Reset
REQ-025 While RST=1 at a clock edge: prescaler, phase, dead counters and duty SHALL be cleared to 0; FSMs SHALL go to COAST; ILLEGAL, BUSY and all bridge outputs SHALL be 0 on the next CLK.
REQ-026 RST asserted mid-DEAD or mid-period SHALL abort immediately with no residual pulse.

Configuration
REQ-027 Macro SOFT_RAMP_EN defined: at each PERIOD_END the applied duty steps by +-1 toward the target; entry to FWD/REV starts at duty 1.
REQ-028 Macro SOFT_RAMP_EN undefined: the applied duty equals the target duty from the PERIOD_END on which the input is sampled.

Structure
REQ-029 Package motor_pkg SHALL hold the direction encodings, state encoding, the duty lookup constant and the DEAD_PERIODS width.
REQ-030 Sub-module motor_channel (FSM, dead counter, duty/ramp, output regs) SHALL be instanced twice; the prescaler and phase counter live in the top level.

Verification (CLK_DIV=4, DEAD_PERIODS=4, period = 32 CLK)
REQ-031 Reset, MC1=5'b00100 -> after first PERIOD_END M1_INA=1, M1_INB=0, M1_PWM high 8 of every 32 clocks.
REQ-032 MC1 00100 -> 00110 while in FWD -> INA=INB=0, BUSY[0]=1 for 128 clocks, then M1_INB=1 with 8/32 duty; INA&INB is never 1.
REQ-033 MC2 power 000 -> 110 mid-period -> current period keeps 4 high clocks; the next period has 28 high clocks.
REQ-034 MC1=5'b00011 -> channel in COAST, ILLEGAL[0]=1; ILLEGAL stays 1 after MC1 returns to 00000 until RST.
REQ-035 RST pulsed during DEAD -> all outputs 0 on the next CLK, FSM in COAST, BUSY=0.
REQ-036 SOFT_RAMP_EN defined, MC1=5'b11100 from COAST -> duty 1,2,...,7 over 7 consecutive periods.
